// File: rtl/tri_bus_pkg.sv
// Shared types and default constants for the tri-state bus reader.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int N_SRC_DEF  = 4;
    localparam int W_DEF      = 1;
    localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/prio_next_sel.sv
// Lowest set mask bit above (or, with incl, at) the current index; none=1 if no such bit.
module prio_next_sel #(
    parameter int N_SRC = 4,
    parameter int IW    = 2
) (
    input  logic [N_SRC-1:0] mask,
    input  logic [IW-1:0]    cur,
    input  logic             incl,
    output logic [IW-1:0]    next,
    output logic             none
);

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        next = '0;
        none = 1'b1;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                next = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tri_bus_reader.sv
// Grants each masked tri-state source in turn, samples the shared bus after a settle
// time, inserts a dead cycle between grants, and presents all samples as one word.
module tri_bus_reader
    import tri_bus_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int W      = W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_SRC-1:0]   src_mask,
    input  logic [W-1:0]       bus_in,
    output logic [N_SRC-1:0]   en,
    output logic               busy,
    output logic               done,
    output logic [N_SRC*W-1:0] data_out
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [N_SRC-1:0]   mask_q;
    logic [N_SRC*W-1:0] shadow;

    logic [N_SRC-1:0]   sel_mask;
    logic [IW-1:0]      sel_cur;
    logic               sel_incl;
    logic [IW-1:0]      sel_next;
    logic               sel_none;

    // In IDLE the live mask is searched from index 0 inclusive; in TURN the latched mask above idx.
    assign sel_incl = (state == IDLE);
    assign sel_mask = sel_incl ? src_mask : mask_q;
    assign sel_cur  = sel_incl ? '0 : idx;

    prio_next_sel #(
        .N_SRC (N_SRC),
        .IW    (IW)
    ) u_sel (
        .mask (sel_mask),
        .cur  (sel_cur),
        .incl (sel_incl),
        .next (sel_next),
        .none (sel_none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        en        = '0;
        busy      = (state != IDLE);
        done      = (state == FINISH);
        case (state)
            IDLE:    if (start) state_nxt = sel_none ? FINISH : DRIVE;
            DRIVE: begin
                en[idx] = 1'b1;
                if (cnt == '0) state_nxt = TURN;
            end
            TURN:    state_nxt = sel_none ? FINISH : DRIVE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            mask_q   <= '0;
            shadow   <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_q <= src_mask;
                    shadow <= '0;
                    if (sel_none) begin
                        data_out <= '0;
                    end else begin
                        idx <= sel_next;
                        cnt <= CNT_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) shadow[int'(idx)*W +: W] <= bus_in;
                    else           cnt <= cnt - 1'b1;
                end
                TURN: begin
                    if (sel_none) begin
                        data_out <= shadow;
                    end else begin
                        idx <= sel_next;
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_reader.sv
// Randomized bench for tri_bus_reader against a cycle-schedule model of the scan.
module tb_tri_bus_reader;

    localparam int N_SRC  = 4;
    localparam int W      = 4;
    localparam int SETTLE = 2;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [N_SRC-1:0]   src_mask;
    logic [W-1:0]       bus_in;
    logic [N_SRC-1:0]   en;
    logic               busy;
    logic               done;
    logic [N_SRC*W-1:0] data_out;

    logic [W-1:0]       src_val [N_SRC];
    logic [N_SRC*W-1:0] last_out;
    int                 n_checks;
    int                 n_errors;

    tri_bus_reader #(
        .N_SRC  (N_SRC),
        .W      (W),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_mask (src_mask),
        .bus_in   (bus_in),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source array: only the enabled source drives the bus.
    always_comb begin
        bus_in = '0;
        for (int k = 0; k < N_SRC; k++)
            if (en[k]) bus_in = src_val[k];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n) check("onehot0_en", 64'($onehot0(en)), 64'd1);

    // One scan: start sampled at t0, then cycles 1..L+1 checked against the schedule.
    task automatic scan(input logic [N_SRC-1:0] mask, input bit noisy);
        int                 sel [$];
        int                 m, len, j, off;
        logic [N_SRC-1:0]   exp_en;
        logic [N_SRC*W-1:0] exp_out;

        for (int k = 0; k < N_SRC; k++) src_val[k] = W'($urandom);
        exp_out = '0;
        for (int k = 0; k < N_SRC; k++)
            if (mask[k]) begin
                sel.push_back(k);
                exp_out[k*W +: W] = src_val[k];
            end
        m   = sel.size();
        len = m * (SETTLE + 1) + 1;

        @(negedge clk);
        start    = 1'b1;
        src_mask = mask;
        @(posedge clk);
        #1 start = 1'b0;

        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            j   = (c - 1) / (SETTLE + 1);
            off = (c - 1) % (SETTLE + 1);
            exp_en = '0;
            if (j < m && off < SETTLE) exp_en[sel[j]] = 1'b1;
            check("en", 64'(en), 64'(exp_en));
            check("busy", 64'(busy), 64'(c <= len));
            check("done", 64'(done), 64'(c == len));
            if (c >= len) check("data_out", 64'(data_out), 64'(exp_out));
            if (noisy && c < len) begin
                start    = 1'($urandom);
                src_mask = N_SRC'($urandom);
            end
            if (noisy && c == len) start = 1'b1;
            if (c == len + 1) start = 1'b0;
        end
        if (noisy) begin
            repeat (2) begin
                @(negedge clk);
                check("no_restart_busy", 64'(busy), 64'd0);
                check("no_restart_en", 64'(en), 64'd0);
            end
        end
        last_out = exp_out;
    endtask

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        src_mask = '0;
        for (int k = 0; k < N_SRC; k++) src_val[k] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_en", 64'(en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
        end

        scan(4'b1111, 1'b0);
        scan(4'b1010, 1'b0);
        scan(4'b0000, 1'b0);
        scan(4'b0001, 1'b0);
        scan(4'b1000, 1'b0);
        scan(4'b1111, 1'b1);
        for (int r = 0; r < 30; r++) scan(N_SRC'($urandom), ($urandom_range(0, 1) == 1));

        // Asynchronous reset while source 1 is granted.
        scan(4'b1111, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        src_mask = 4'b1111;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (en == 4'b0010) found = 1'b1;
        end
        check("rst_reach_drive1", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", 64'(en), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_data", 64'(data_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_en", 64'(en), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        scan(4'b0110, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
